// File: rtl/baud_pkg.sv
// Shared defaults and helpers for the baud tick generator.
package baud_pkg;

    localparam int unsigned DEF_NUM_CH     = 2;
    localparam int unsigned DEF_DIV_W      = 16;
    localparam int unsigned DEF_FRAC_W     = 4;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    // Oversample phase at which the mid-bit sample tick fires.
    function automatic int unsigned midPhase(input int unsigned oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/baud_tick_ch.sv
// One baud timing channel: fractional period counter, oversample phase and tick pulses.
// Optional legacy square-wave output when BAUD_TICK_GEN_CLKOUT_EN is defined.
module baud_tick_ch
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned FRAC_W     = DEF_FRAC_W,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    localparam int unsigned OS_W      = $clog2(OVERSAMPLE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              resync,
    input  logic [DIV_W-1:0]  divInt,
    input  logic [FRAC_W-1:0] divFrac,
    output logic              osTick,
    output logic              baudTick,
    output logic              sampleTick,
    output logic [OS_W-1:0]   osPhase
`ifdef BAUD_TICK_GEN_CLKOUT_EN
    ,
    output logic              baudClk
`endif
);

    localparam logic [OS_W-1:0] MID = OS_W'(midPhase(OVERSAMPLE));

    // One extra counter bit so divLat + extend never wraps at divInt = all-ones.
    logic [DIV_W:0]    cnt;
    logic [FRAC_W-1:0] acc;
    logic              extend;
    logic [OS_W-1:0]   phase;
    logic [DIV_W-1:0]  divLat;
    logic [FRAC_W-1:0] divFracLat;
    logic              enQ;

    logic              start;
    logic [DIV_W:0]    termVal;
    logic              terminal;
    logic [FRAC_W:0]   fracSum;
    logic [OS_W-1:0]   phaseNext;

    // A start (enable rise or resync) behaves like a fresh post-reset channel.
    assign start     = en & (~enQ | resync);
    assign termVal   = {1'b0, divLat} + {{DIV_W{1'b0}}, extend};
    assign terminal  = (cnt == termVal);
    assign fracSum   = {1'b0, acc} + {1'b0, divFracLat};
    assign phaseNext = phase + OS_W'(1);
    assign osPhase   = phase;

    // Period counter, fractional accumulator, phase and registered tick pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            acc        <= '0;
            extend     <= 1'b0;
            phase      <= '0;
            divLat     <= '0;
            divFracLat <= '0;
            enQ        <= 1'b0;
            osTick     <= 1'b0;
            baudTick   <= 1'b0;
            sampleTick <= 1'b0;
        end else if (!en) begin
            cnt        <= '0;
            acc        <= '0;
            extend     <= 1'b0;
            phase      <= '0;
            enQ        <= 1'b0;
            osTick     <= 1'b0;
            baudTick   <= 1'b0;
            sampleTick <= 1'b0;
        end else if (start) begin
            // Any tick that would have fired on this edge is dropped.
            cnt        <= '0;
            acc        <= '0;
            extend     <= 1'b0;
            phase      <= '0;
            divLat     <= divInt;
            divFracLat <= divFrac;
            enQ        <= 1'b1;
            osTick     <= 1'b0;
            baudTick   <= 1'b0;
            sampleTick <= 1'b0;
        end else if (terminal) begin
            cnt        <= '0;
            acc        <= fracSum[FRAC_W-1:0];
            extend     <= fracSum[FRAC_W];
            phase      <= phaseNext;
            divLat     <= divInt;
            divFracLat <= divFrac;
            osTick     <= 1'b1;
            baudTick   <= (phaseNext == '0);
            sampleTick <= (phaseNext == MID);
        end else begin
            cnt        <= cnt + (DIV_W+1)'(1);
            osTick     <= 1'b0;
            baudTick   <= 1'b0;
            sampleTick <= 1'b0;
        end
    end

`ifdef BAUD_TICK_GEN_CLKOUT_EN
    // Square wave toggling on bit boundary and mid-bit, aligned with the tick pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baudClk <= 1'b0;
        end else if (!en || start) begin
            baudClk <= 1'b0;
        end else if (terminal && ((phaseNext == '0) || (phaseNext == MID))) begin
            baudClk <= ~baudClk;
        end
    end
`endif

endmodule

// File: rtl/baud_tick_gen.sv
// Multi-channel baud timing generator: one baud_tick_ch per channel plus port slicing.
// Define BAUD_TICK_GEN_CLKOUT_EN to add the legacy baud_clk square-wave output.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned FRAC_W     = DEF_FRAC_W,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    localparam int unsigned OS_W      = $clog2(OVERSAMPLE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        en,
    input  logic [NUM_CH*DIV_W-1:0]  div_int,
    input  logic [NUM_CH*FRAC_W-1:0] div_frac,
    input  logic [NUM_CH-1:0]        resync,
    output logic [NUM_CH-1:0]        os_tick,
    output logic [NUM_CH-1:0]        baud_tick,
    output logic [NUM_CH-1:0]        sample_tick,
    output logic [NUM_CH*OS_W-1:0]   os_phase
`ifdef BAUD_TICK_GEN_CLKOUT_EN
    ,
    output logic [NUM_CH-1:0]        baud_clk
`endif
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
        baud_tick_ch #(
            .DIV_W      (DIV_W),
            .FRAC_W     (FRAC_W),
            .OVERSAMPLE (OVERSAMPLE)
        ) uCh (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en[ch]),
            .resync     (resync[ch]),
            .divInt     (div_int[ch*DIV_W +: DIV_W]),
            .divFrac    (div_frac[ch*FRAC_W +: FRAC_W]),
            .osTick     (os_tick[ch]),
            .baudTick   (baud_tick[ch]),
            .sampleTick (sample_tick[ch]),
            .osPhase    (os_phase[ch*OS_W +: OS_W])
`ifdef BAUD_TICK_GEN_CLKOUT_EN
            ,
            .baudClk    (baud_clk[ch])
`endif
        );
    end

endmodule
